bitserial_logic_ctrl: RTL and testbench

Control and compute stage for the bit-serial logic processor. It drives the load and shift strobes of the dual 8-bit shift-register unit, and consumes that unit's serial outputs (A_out, B_out). It computes a selectable bitwise function on each bit pair and routes the result back into the registers' serial inputs (A_In, B_In). One Execute runs one full pass of WIDTH shifts, so each register ends with its new word.

---
 rtl/bitserial_logic_ctrl.sv | 86 ++++++++
 tb/tb_bitserial_logic_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/bitserial_logic_ctrl.sv
// bitserial_logic_ctrl: sequences load/shift strobes for two serial registers and routes f(A_out,B_out) back in.
// Optional Busy/Done status ports are added when LOGIC_STATUS_EN is defined.
module bitserial_logic_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Execute,
    input  logic       LoadA,
    input  logic       LoadB,
    input  logic [2:0] F,
    input  logic [1:0] R,
    input  logic       A_out,
    input  logic       B_out,
    output logic       Ld_A,
    output logic       Ld_B,
    output logic       Shift_En,
    output logic       A_In,
    output logic       B_In
`ifdef LOGIC_STATUS_EN
    ,
    output logic       Busy,
    output logic       Done
`endif
);
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0] f_q, f_d;
    logic [1:0] r_q, r_d;
    logic last, base, fv;
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            f_q     <= '0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            f_q     <= f_d;
            r_q     <= r_d;
        end
    end
    assign last = cnt_q == CNT_W'(WIDTH - 1);
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        f_d     = f_q;
        r_d     = r_q;
        case (state_q)
            IDLE: if (Execute) begin
                state_d = SHIFT;
                cnt_d   = '0;
                f_d     = F;
                r_d     = R;
            end
            SHIFT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (last) state_d = Execute ? HOLD : IDLE;
            end
            HOLD: if (!Execute) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // f_q[2] inverts the base function selected by f_q[1:0]; 011/111 give constant 1/0
    assign base = f_q[1:0] == 2'b00 ? (A_out & B_out) :
                  f_q[1:0] == 2'b01 ? (A_out | B_out) :
                  f_q[1:0] == 2'b10 ? (A_out ^ B_out) : 1'b1;
    assign fv       = f_q[2] ^ base;
    assign Shift_En = state_q == SHIFT;
    assign Ld_A     = state_q == IDLE && !Execute && !Reset && LoadA;
    assign Ld_B     = state_q == IDLE && !Execute && !Reset && LoadB;
    assign A_In     = Shift_En & (r_q == 2'b10 ? fv : r_q == 2'b11 ? B_out : A_out);
    assign B_In     = Shift_En & (r_q == 2'b01 ? fv : r_q == 2'b11 ? A_out : B_out);
`ifdef LOGIC_STATUS_EN
    logic done_q;
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) done_q <= 1'b0;
        else       done_q <= Shift_En && last;
    end
    assign Busy = state_q != IDLE;
    assign Done = done_q;
`endif
endmodule

// File: tb/tb_bitserial_logic_ctrl.sv
// tb_bitserial_logic_ctrl: drives the controller against a behavioural pair of 8-bit shift registers.
module tb_bitserial_logic_ctrl;
    logic       Clk = 0, Reset = 1, Execute = 1, LoadA = 1, LoadB = 1;
    logic [2:0] F = 0;
    logic [1:0] R = 0;
    logic       A_out, B_out, Ld_A, Ld_B, Shift_En, A_In, B_In;
`ifdef LOGIC_STATUS_EN
    logic       Busy, Done;
`endif
    logic [7:0] a_reg = 0, b_reg = 0, sw_a = 0, sw_b = 0;
    logic [15:0] sb[$];
    int checks = 0, failures = 0;

    bitserial_logic_ctrl dut (
        .Clk(Clk), .Reset(Reset), .Execute(Execute), .LoadA(LoadA), .LoadB(LoadB),
        .F(F), .R(R), .A_out(A_out), .B_out(B_out), .Ld_A(Ld_A), .Ld_B(Ld_B),
        .Shift_En(Shift_En), .A_In(A_In), .B_In(B_In)
`ifdef LOGIC_STATUS_EN
        , .Busy(Busy), .Done(Done)
`endif
    );

    always #5 Clk = ~Clk;
    assign A_out = a_reg[0];
    assign B_out = b_reg[0];
    always @(posedge Clk) begin
        if (Ld_A) a_reg <= sw_a;
        else if (Shift_En) a_reg <= {A_In, a_reg[7:1]};
        if (Ld_B) b_reg <= sw_b;
        else if (Shift_En) b_reg <= {B_In, b_reg[7:1]};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] fn(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
        case (f)
            3'b000: return a & b;
            3'b001: return a | b;
            3'b010: return a ^ b;
            3'b011: return 8'hFF;
            3'b100: return ~(a & b);
            3'b101: return ~(a | b);
            3'b110: return ~(a ^ b);
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] f, input logic [1:0] r);
        case (r)
            2'b00: return {a, b};
            2'b01: return {a, fn(f, a, b)};
            2'b10: return {fn(f, a, b), b};
            default: return {b, a};
        endcase
    endfunction

    task automatic load_ab(input logic [7:0] a, input logic [7:0] b);
        @(negedge Clk); sw_a = a; LoadA = 1;
        #1 check("ld_a", Ld_A, 1); check("ld_a_only", Ld_B, 0);
        @(negedge Clk); LoadA = 0; sw_b = b; LoadB = 1;
        #1 check("ld_b", Ld_B, 1); check("ld_b_only", Ld_A, 0);
        @(negedge Clk); LoadB = 0;
        check("loaded", {a_reg, b_reg}, {a, b});
    endtask

    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] f,
                         input logic [1:0] r, input int hold, input logic ld);
        int n;
        logic prev;
        logic [15:0] exp;
        load_ab(a, b);
        sb.push_back(model(a, b, f, r));
        @(negedge Clk); F = f; R = r; Execute = 1; LoadA = ld;
        #1 if (ld) check("exec_prio", Ld_A, 0);
        n = 0;
        prev = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge Clk);
            if (Shift_En) n++;
            if (c == 3 && ld) begin
                check("ld_ignored", Ld_A, 0);
                LoadA = 0;
            end
`ifdef LOGIC_STATUS_EN
            check("done", Done, prev && !Shift_En);
            check("busy", Busy, c < (hold > 8 ? hold : 8));
`endif
            prev = Shift_En;
            if (c == 12 && hold > 13) begin
                LoadA = 1;
                #1 check("ld_hold", Ld_A, 0);
                LoadA = 0;
            end
            F = ~f;
            if (c + 1 >= hold) Execute = 0;
        end
        check("shift_cnt", n, 8);
        exp = sb.pop_front();
        check("result", {a_reg, b_reg}, exp);
    endtask

    initial begin
        #2 check("rst_outs", {Ld_A, Ld_B, Shift_En, A_In, B_In}, 0);
        @(negedge Clk); Execute = 0; LoadA = 0; LoadB = 0; Reset = 0;
        repeat (3) begin
            @(negedge Clk);
            check("idle_after_rst", Shift_En, 0);
        end
        do_op(8'h33, 8'h55, 3'b000, 2'b01, 1, 0);
        do_op(8'h33, 8'h55, 3'b010, 2'b10, 1, 1);
        do_op(8'h33, 8'h55, 3'($urandom_range(0, 7)), 2'b11, 1, 0);
        do_op(8'h33, 8'h55, 3'b010, 2'b01, 20, 0);
        for (int i = 0; i < 8; i++)
            do_op(8'($urandom), 8'($urandom), 3'(i), 2'($urandom_range(0, 3)), 1 + (i % 2) * 14, 0);
        load_ab(8'hA5, 8'h3C);
        @(negedge Clk); F = 3'b000; R = 2'b01; Execute = 1;
        repeat (3) @(negedge Clk);
        check("mid_shift", Shift_En, 1);
        Execute = 0;
        #2 Reset = 1;
        #1 check("rst_mid", {Ld_A, Ld_B, Shift_En, A_In, B_In}, 0);
        @(negedge Clk); Reset = 0;
        repeat (4) begin
            @(negedge Clk);
            check("idle_after_mid_rst", Shift_En, 0);
        end
        do_op(8'hC3, 8'h0F, 3'b101, 2'b01, 1, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
